// File: rtl/id_ex_operand_stage.sv
// ID->EX pipeline register with MEM/WB operand bypass,
// load-use hazard detection, bubble insertion, stall and flush.
module id_ex_operand_stage #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic [4:0]        id_rd,
    input  logic              id_rfwr,
    input  logic              id_is_load,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [XLEN-1:0]   rf_rd1,
    input  logic [XLEN-1:0]   rf_rd2,
    input  logic              mem_rfwr,
    input  logic [4:0]        mem_rd,
    input  logic [XLEN-1:0]   mem_wd,
    input  logic              mem_is_load,
    input  logic              wb_rfwr,
    input  logic [4:0]        wb_rd,
    input  logic [XLEN-1:0]   wb_wd,
    input  logic              ex_stall,
    input  logic              flush,
    output logic              id_stall,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [4:0]        ex_rs1,
    output logic [4:0]        ex_rs2,
    output logic [4:0]        ex_rd,
    output logic              ex_rfwr,
    output logic              ex_is_load,
    output logic [XLEN-1:0]   ex_imm,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [XLEN-1:0]   ex_op1,
    output logic [XLEN-1:0]   ex_op2
);

    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic            pend1;
    logic            pend2;
    logic            hazard;
    logic            bubble;

    // MEM beats WB beats RF; x0 always reads zero
    function automatic logic [XLEN-1:0] resolve(
        input logic [4:0]      rs,
        input logic [XLEN-1:0] rf_val,
        input logic            m_wr,
        input logic [4:0]      m_rd,
        input logic [XLEN-1:0] m_wd,
        input logic            w_wr,
        input logic [4:0]      w_rd,
        input logic [XLEN-1:0] w_wd
    );
        if (rs == 5'd0)
            return '0;
        else if (m_wr && m_rd == rs)
            return m_wd;
        else if (w_wr && w_rd == rs)
            return w_wd;
        else
            return rf_val;
    endfunction

    // Source waits on a load still in EX or MEM
    function automatic logic load_pending(
        input logic       rs,
        input logic [4:0] src,
        input logic       e_ld,
        input logic [4:0] e_rd,
        input logic       m_ld,
        input logic [4:0] m_rd
    );
        return rs && src != 5'd0 &&
               ((e_ld && e_rd == src) || (m_ld && m_rd == src));
    endfunction

    // Operand resolve and hazard/stall decision
    always_comb begin
        op1 = resolve(id_rs1, rf_rd1, mem_rfwr, mem_rd, mem_wd,
                      wb_rfwr, wb_rd, wb_wd);
        op2 = resolve(id_rs2, rf_rd2, mem_rfwr, mem_rd, mem_wd,
                      wb_rfwr, wb_rd, wb_wd);
        pend1 = load_pending(1'b1, id_rs1,
                             ex_valid && ex_rfwr && ex_is_load, ex_rd,
                             mem_rfwr && mem_is_load, mem_rd);
        pend2 = load_pending(1'b1, id_rs2,
                             ex_valid && ex_rfwr && ex_is_load, ex_rd,
                             mem_rfwr && mem_is_load, mem_rd);
        hazard   = id_valid && (pend1 || pend2);
        id_stall = hazard || ex_stall;
        // flush wins over stall; an empty ID slot is also a bubble
        bubble   = flush || (!ex_stall && (hazard || !id_valid));
    end

    // EX register: reset, bubble, hold on stall, else capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst || bubble) begin
            ex_valid   <= 1'b0;
            ex_pc      <= '0;
            ex_rs1     <= '0;
            ex_rs2     <= '0;
            ex_rd      <= '0;
            ex_rfwr    <= 1'b0;
            ex_is_load <= 1'b0;
            ex_imm     <= '0;
            ex_ctrl    <= '0;
            ex_op1     <= '0;
            ex_op2     <= '0;
        end else if (!ex_stall) begin
            ex_valid   <= id_valid;
            ex_pc      <= id_pc;
            ex_rs1     <= id_rs1;
            ex_rs2     <= id_rs2;
            ex_rd      <= id_rd;
            ex_rfwr    <= id_rfwr;
            ex_is_load <= id_is_load;
            ex_imm     <= id_imm;
            ex_ctrl    <= id_ctrl;
            ex_op1     <= op1;
            ex_op2     <= op2;
        end
    end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench for id_ex_operand_stage: directed cases
// from the block's feature list plus randomized traffic.
module tb_id_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_valid, id_rfwr, id_is_load;
    logic [31:0] id_pc, id_imm, rf_rd1, rf_rd2;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [15:0] id_ctrl;
    logic        mem_rfwr, mem_is_load, wb_rfwr;
    logic [4:0]  mem_rd, wb_rd;
    logic [31:0] mem_wd, wb_wd;
    logic        ex_stall, flush;
    logic        id_stall, ex_valid, ex_rfwr, ex_is_load;
    logic [31:0] ex_pc, ex_imm, ex_op1, ex_op2;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [15:0] ex_ctrl;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rfwr;
        logic        is_load;
        logic [31:0] imm;
        logic [15:0] ctrl;
        logic [31:0] op1;
        logic [31:0] op2;
    } ex_t;

    typedef struct packed {
        logic        rst;
        logic        id_valid;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rfwr;
        logic        is_load;
        logic [31:0] imm;
        logic [15:0] ctrl;
        logic [31:0] rf1;
        logic [31:0] rf2;
        logic        m_wr;
        logic [4:0]  m_rd;
        logic [31:0] m_wd;
        logic        m_ld;
        logic        w_wr;
        logic [4:0]  w_rd;
        logic [31:0] w_wd;
        logic        stall;
        logic        flush;
    } stim_t;

    int   errors = 0;
    int   checks = 0;
    ex_t  model  = '0;
    ex_t  q_cur[$];
    ex_t  q_nxt[$];
    logic q_stall[$];

    id_ex_operand_stage dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rfwr(id_rfwr), .id_is_load(id_is_load),
        .id_imm(id_imm), .id_ctrl(id_ctrl),
        .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .mem_rfwr(mem_rfwr), .mem_rd(mem_rd), .mem_wd(mem_wd),
        .mem_is_load(mem_is_load),
        .wb_rfwr(wb_rfwr), .wb_rd(wb_rd), .wb_wd(wb_wd),
        .ex_stall(ex_stall), .flush(flush),
        .id_stall(id_stall),
        .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_rfwr(ex_rfwr), .ex_is_load(ex_is_load),
        .ex_imm(ex_imm), .ex_ctrl(ex_ctrl),
        .ex_op1(ex_op1), .ex_op2(ex_op2)
    );

    always #5 clk = ~clk;

    function automatic ex_t observed();
        ex_t a;
        a = '{ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_rfwr,
              ex_is_load, ex_imm, ex_ctrl, ex_op1, ex_op2};
        return a;
    endfunction

    // Value an instruction in ID sees for register r: the youngest
    // in-flight writer wins (MEM is younger than WB), then the RF.
    function automatic logic [31:0] source_value(
        input stim_t s, input logic [4:0] r, input logic [31:0] rf);
        logic        wr[2];
        logic [4:0]  dst[2];
        logic [31:0] val[2];
        if (r == 0) return 32'h0;
        wr  = '{s.m_wr, s.w_wr};
        dst = '{s.m_rd, s.w_rd};
        val = '{s.m_wd, s.w_wd};
        for (int k = 0; k < 2; k++)
            if (wr[k] && dst[k] == r) return val[k];
        return rf;
    endfunction

    // Register r is the target of a load whose data isn't ready
    function automatic bit waits_on_load(
        input stim_t s, input ex_t e, input logic [4:0] r);
        logic [4:0] loads[$];
        if (e.valid && e.rfwr && e.is_load) loads.push_back(e.rd);
        if (s.m_wr && s.m_ld) loads.push_back(s.m_rd);
        if (r == 0) return 0;
        foreach (loads[k]) if (loads[k] == r) return 1;
        return 0;
    endfunction

    function automatic stim_t nop();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s          = '0;
        s.rst      = ($urandom_range(99) == 0);
        s.id_valid = ($urandom_range(9) < 8);
        s.pc       = $urandom;
        s.rs1      = 5'($urandom_range(7));
        s.rs2      = 5'($urandom_range(7));
        s.rd       = 5'($urandom_range(7));
        s.rfwr     = $urandom_range(1);
        s.is_load  = ($urandom_range(3) == 0);
        s.imm      = $urandom;
        s.ctrl     = 16'($urandom);
        s.rf1      = $urandom;
        s.rf2      = $urandom;
        s.m_wr     = $urandom_range(1);
        s.m_rd     = 5'($urandom_range(7));
        s.m_wd     = $urandom;
        s.m_ld     = ($urandom_range(3) == 0);
        s.w_wr     = $urandom_range(1);
        s.w_rd     = 5'($urandom_range(7));
        s.w_wd     = $urandom;
        s.stall    = ($urandom_range(4) == 0);
        s.flush    = ($urandom_range(9) == 0);
        return s;
    endfunction

    task automatic step(input stim_t s);
        ex_t cur;
        ex_t nxt;
        bit  haz;
        @(negedge clk);
        #1;
        rst = s.rst; id_valid = s.id_valid; id_pc = s.pc;
        id_rs1 = s.rs1; id_rs2 = s.rs2; id_rd = s.rd;
        id_rfwr = s.rfwr; id_is_load = s.is_load;
        id_imm = s.imm; id_ctrl = s.ctrl;
        rf_rd1 = s.rf1; rf_rd2 = s.rf2;
        mem_rfwr = s.m_wr; mem_rd = s.m_rd; mem_wd = s.m_wd;
        mem_is_load = s.m_ld;
        wb_rfwr = s.w_wr; wb_rd = s.w_rd; wb_wd = s.w_wd;
        ex_stall = s.stall; flush = s.flush;
        cur = s.rst ? ex_t'('0) : model;
        haz = s.id_valid && (waits_on_load(s, cur, s.rs1) ||
                             waits_on_load(s, cur, s.rs2));
        q_cur.push_back(cur);
        q_stall.push_back(haz || s.stall);
        if (s.rst || s.flush)
            nxt = '0;
        else if (s.stall)
            nxt = cur;
        else if (haz || !s.id_valid)
            nxt = '0;
        else
            nxt = '{1'b1, s.pc, s.rs1, s.rs2, s.rd, s.rfwr, s.is_load,
                    s.imm, s.ctrl, source_value(s, s.rs1, s.rf1),
                    source_value(s, s.rs2, s.rf2)};
        model = nxt;
        q_nxt.push_back(nxt);
    endtask

    // Mid-cycle monitor: combinational stall and current EX state
    initial forever begin
        ex_t  e;
        logic st;
        @(negedge clk);
        #3;
        if (q_cur.size() > 0) begin
            e  = q_cur.pop_front();
            st = q_stall.pop_front();
            checks += 2;
            if (id_stall !== st) begin
                errors++;
                $display("FAIL id_stall t=%0t actual=%b required=%b",
                         $time, id_stall, st);
            end
            if (observed() !== e) begin
                errors++;
                $display("FAIL ex_hold t=%0t actual=%h required=%h",
                         $time, observed(), e);
            end
        end
    end

    // Post-edge monitor: captured EX register contents
    initial forever begin
        ex_t e;
        @(posedge clk);
        #1;
        if (q_nxt.size() > 0) begin
            e = q_nxt.pop_front();
            checks++;
            if (observed() !== e) begin
                errors++;
                $display("FAIL ex_capture t=%0t actual=%h required=%h",
                         $time, observed(), e);
            end
        end
    end

    initial begin
        stim_t s;
        int    waited;
        s = nop(); s.rst = 1'b1;
        step(s);
        step(s);
        // WB bypass over stale RF data
        s = nop(); s.id_valid = 1; s.rs1 = 5; s.pc = 32'h100;
        s.w_wr = 1; s.w_rd = 5; s.w_wd = 32'hDEAD_BEEF;
        step(s);
        // MEM beats WB, then x0 on rs2
        s = nop(); s.id_valid = 1; s.rs2 = 7; s.rf2 = 32'h33;
        s.m_wr = 1; s.m_rd = 7; s.m_wd = 32'h11;
        s.w_wr = 1; s.w_rd = 7; s.w_wd = 32'h22;
        step(s);
        s.rs2 = 0;
        step(s);
        // x0 write in WB and a load to x0 raise nothing
        s = nop(); s.id_valid = 1; s.rs1 = 0;
        s.w_wr = 1; s.w_rd = 0; s.w_wd = 32'hFFFF_FFFF;
        s.rd = 0; s.rfwr = 1; s.is_load = 1;
        step(s);
        s = nop(); s.id_valid = 1; s.rs1 = 0; s.rs2 = 0;
        step(s);
        // lw x3 then add x4,x3,x3: two bubbles then WB data
        s = nop(); s.id_valid = 1; s.rs1 = 1; s.rd = 3;
        s.rfwr = 1; s.is_load = 1;
        step(s);
        s = nop(); s.id_valid = 1; s.rs1 = 3; s.rs2 = 3;
        s.rd = 4; s.rfwr = 1;
        step(s);
        s.m_wr = 1; s.m_rd = 3; s.m_ld = 1;
        step(s);
        s.m_wr = 0; s.m_ld = 0;
        s.w_wr = 1; s.w_rd = 3; s.w_wd = 32'hCAFE_0003;
        step(s);
        // flush with stall, then a plain two-cycle hold
        s = nop(); s.id_valid = 1; s.pc = 32'h200; s.rd = 9;
        s.rfwr = 1; s.ctrl = 16'hA5A5;
        step(s);
        s.flush = 1; s.stall = 1;
        step(s);
        s = nop(); s.id_valid = 1; s.pc = 32'h300; s.imm = 32'h55;
        step(s);
        s = rand_stim(); s.rst = 0; s.flush = 0; s.stall = 1;
        step(s);
        step(s);
        // reset mid-run drops the held instruction
        s = nop(); s.id_valid = 1; s.pc = 32'h400; s.rs1 = 2;
        s.rf1 = 32'h77;
        step(s);
        s.rst = 1;
        step(s);
        s = nop();
        step(s);
        for (int i = 0; i < 400; i++) step(rand_stim());
        s = nop();
        step(s);
        waited = 0;
        while ((q_cur.size() > 0 || q_nxt.size() > 0) && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        @(negedge clk);
        checks++;
        if (q_cur.size() > 0 || q_nxt.size() > 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0",
                     q_cur.size() + q_nxt.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
